// File: rtl/pool_pkg.sv
// pool_pkg: fp16 constants, mode, state and alu op encodings shared by the pooling path
package pool_pkg;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, DONE} state_t;
  typedef enum logic [1:0] {OP_MAX, OP_ADD, OP_MUL} alu_op_t;
endpackage

// File: rtl/fp16_alu.sv
// fp16_alu: combinational fp16 max/add/mul (op, a, b -> y) with flush-to-zero, RNE, canonical NaN
module fp16_alu
  import pool_pkg::*;
(
  input  alu_op_t     op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  function automatic logic [3:0] lzc(input logic [13:0] v);
    lzc = 4'd14;
    for (int i = 0; i < 14; i++) lzc = v[i] ? 4'(13 - i) : lzc;
  endfunction
  function automatic logic [15:0] pack(input logic s, input logic signed [7:0] e, input logic [13:0] n);
    logic [11:0] m;
    logic signed [7:0] x;
    m = {1'b0, n[13:3]} + {11'b0, n[2] & (n[3] | n[1] | n[0])};
    x = m[11] ? e + 8'sd1 : e;
    m = m[11] ? m >> 1 : m;
    return x > 8'sd30 ? {s, 15'h7C00} : x < 8'sd1 ? {s, 15'h0000} : {s, x[4:0], m[9:0]};
  endfunction
  logic              an, bn, ai, bi, az, bz, sw, sp;
  logic [15:0]       fa, fb, bg, sm, ka, kb, add_y, mul_y;
  logic [4:0]        d;
  logic [26:0]       sh;
  logic [13:0]       big, sml, nrm;
  logic [14:0]       sum;
  logic [3:0]        lz;
  logic [21:0]       p;
  logic signed [7:0] ae, me;
  always_comb begin
    an = &a[14:10] & |a[9:0];
    bn = &b[14:10] & |b[9:0];
    ai = &a[14:10] & ~|a[9:0];
    bi = &b[14:10] & ~|b[9:0];
    az = ~|a[14:10];
    bz = ~|b[14:10];
    sp = a[15] ^ b[15];
    fa = az ? {a[15], 15'h0} : a;
    fb = bz ? {b[15], 15'h0} : b;
    ka = fa[15] ? ~fa : {1'b1, fa[14:0]};
    kb = fb[15] ? ~fb : {1'b1, fb[14:0]};
    sw = fb[14:0] > fa[14:0];
    bg = sw ? fb : fa;
    sm = sw ? fa : fb;
    d = bg[14:10] - sm[14:10];
    sh = {1'b1, sm[9:0], 16'h0} >> (d > 5'd15 ? 5'd15 : d);
    big = {1'b1, bg[9:0], 3'b0};
    sml = sh[26:13] | {13'b0, |sh[12:0]};
    sum = bg[15] == sm[15] ? {1'b0, big} + {1'b0, sml} : {1'b0, big} - {1'b0, sml};
    lz = lzc(sum[13:0]);
    nrm = sum[14] ? sum[14:1] | {13'b0, sum[0]} : sum[13:0] << lz;
    ae = sum[14] ? $signed({3'b0, bg[14:10]}) + 8'sd1 : $signed({3'b0, bg[14:10]}) - $signed({4'b0, lz});
    add_y = sum == 15'h0 ? FP16_ZERO : pack(bg[15], ae, nrm);
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    me = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15 + $signed({7'b0, p[21]});
    mul_y = pack(sp, me, p[21] ? {p[21:9], |p[8:0]} : {p[20:8], |p[7:0]});
    y = op == OP_MAX ? (an | bn ? FP16_QNAN : ka >= kb ? fa : fb)
      : op == OP_ADD ? (an | bn | (ai & bi & sp) ? FP16_QNAN : ai ? a : bi ? b
                        : az & bz ? {a[15] & b[15], 15'h0} : az ? b : bz ? a : add_y)
      : (an | bn | (ai & bz) | (az & bi) ? FP16_QNAN : ai | bi ? {sp, 15'h7C00}
         : az | bz ? {sp, 15'h0} : mul_y);
  end
endmodule

// File: rtl/pool_kxk_stream.sv
// pool_kxk_stream: streams a ksize x ksize fp16 window (in_valid/in_ready) into one MAX or scaled-AVG result om with pool_valid/err
module pool_kxk_stream
  import pool_pkg::*;
#(
  parameter int KMAX  = 13,
  parameter int CNT_W = $clog2(KMAX * KMAX + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pool_ready,
  input  logic [3:0]  ksize,
  input  logic        mode,
  input  logic [15:0] avg_scale,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [15:0] om,
  output logic        pool_valid,
  output logic        err
);
  state_t             state, state_d;
  alu_op_t            op;
  logic [3:0]         k_q;
  logic               mode_q, err_q, bad, acc_en, last;
  logic [15:0]        scale_q, acc, alu_b, alu_y;
  logic [CNT_W-1:0]   cnt;
  assign bad        = ksize == 4'd0 || int'(ksize) > KMAX;
  assign acc_en     = state == ACCUM && in_valid;
  assign last       = cnt == CNT_W'(int'(k_q) * int'(k_q) - 1);
  assign in_ready   = state == ACCUM;
  assign pool_valid = state == DONE;
  assign err        = pool_valid & err_q;
  assign op         = state == SCALE ? OP_MUL : mode_q == MODE_AVG ? OP_ADD : OP_MAX;
  assign alu_b      = state == SCALE ? scale_q : in_data;
  fp16_alu u_alu (.op(op), .a(acc), .b(alu_b), .y(alu_y));
  always_comb begin
    state_d = state == IDLE  ? (pool_ready ? (bad ? DONE : ACCUM) : IDLE)
            : state == ACCUM ? (acc_en && last ? (mode_q == MODE_AVG ? SCALE : DONE) : ACCUM)
            : state == SCALE ? DONE
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= FP16_ZERO;
      cnt     <= '0;
      om      <= FP16_ZERO;
      err_q   <= 1'b0;
      k_q     <= 4'd0;
      mode_q  <= MODE_MAX;
      scale_q <= FP16_ZERO;
    end else begin
      if (state == IDLE && pool_ready) begin
        k_q     <= ksize;
        mode_q  <= mode;
        scale_q <= avg_scale;
        err_q   <= bad;
        cnt     <= '0;
        acc     <= mode == MODE_MAX ? FP16_NEG_INF : FP16_ZERO;
        if (bad) om <= FP16_ZERO;
      end
      if (acc_en) begin
        acc <= alu_y;
        cnt <= cnt + CNT_W'(1);
        if (last && mode_q == MODE_MAX) om <= alu_y;
      end
      if (state == SCALE) om <= alu_y;
    end
  end
endmodule

// File: tb/tb_pool_kxk_stream.sv
// tb_pool_kxk_stream: randomized and directed checks of pool_kxk_stream against a real-arithmetic fp16 model
module tb_pool_kxk_stream;
  logic        clk = 0, rst_n = 0, pool_ready = 0, mode = 0, in_valid = 0;
  logic [3:0]  ksize = 0;
  logic [15:0] avg_scale = 0, in_data = 0;
  logic        in_ready, pool_valid, err;
  logic [15:0] om;
  int          checks = 0, errors = 0;
  logic [15:0] win[$];
  logic [15:0] r_om;
  logic        r_err, saw_rdy, post_valid, post_rdy;
  int          lat;
  always #5 clk = ~clk;
  pool_kxk_stream #(.KMAX(13)) dut (
    .clk(clk), .rst_n(rst_n), .pool_ready(pool_ready), .ksize(ksize), .mode(mode),
    .avg_scale(avg_scale), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .om(om), .pool_valid(pool_valid), .err(err)
  );
  function automatic bit is_nan(input logic [15:0] h);
    return &h[14:10] && |h[9:0];
  endfunction
  function automatic bit is_inf(input logic [15:0] h);
    return &h[14:10] && !(|h[9:0]);
  endfunction
  function automatic bit is_zero(input logic [15:0] h);
    return h[14:10] == 5'd0;
  endfunction
  function automatic logic [15:0] flush(input logic [15:0] h);
    return is_zero(h) ? {h[15], 15'h0} : h;
  endfunction
  function automatic real f2r(input logic [15:0] h);
    real v;
    v = is_zero(h) ? 0.0 : h[14:10] == 5'd31 ? 1.0e9 : 1.0 + real'(h[9:0]) / 1024.0;
    for (int i = 0; i < int'(h[14:10]); i++) v = v * 2.0;
    v = v / 32768.0;
    return h[15] ? -v : v;
  endfunction
  function automatic logic [15:0] r2f(input real x);
    logic s;
    real  a, m, f;
    int   e, q;
    s = x < 0.0;
    a = s ? -x : x;
    e = 0;
    if (a == 0.0) return 16'h0000;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = a * 1024.0;
    q = int'($floor(m));
    f = m - real'(q);
    if (f > 0.5 || (f == 0.5 && q % 2 == 1)) q++;
    if (q == 2048) begin q = 1024; e++; end
    if (e > 15) return {s, 15'h7C00};
    if (e < -14) return {s, 15'h0000};
    return {s, 5'(e + 15), 10'(q - 1024)};
  endfunction
  function automatic logic [15:0] m_max(input logic [15:0] a, input logic [15:0] b);
    real va, vb;
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    va = f2r(a);
    vb = f2r(b);
    if (va > vb) return flush(a);
    if (va < vb) return flush(b);
    if (va == 0.0) return {a[15] & b[15], 15'h0};
    return a;
  endfunction
  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    real v;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a[15] != b[15])) return 16'h7E00;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    if (is_zero(a) && is_zero(b)) return {a[15] & b[15], 15'h0};
    if (is_zero(a)) return b;
    if (is_zero(b)) return a;
    v = f2r(a) + f2r(b);
    return v == 0.0 ? 16'h0000 : r2f(v);
  endfunction
  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return 16'h7E00;
    if (is_inf(a) || is_inf(b)) return {a[15] ^ b[15], 15'h7C00};
    if (is_zero(a) || is_zero(b)) return {a[15] ^ b[15], 15'h0};
    return r2f(f2r(a) * f2r(b));
  endfunction
  function automatic logic [15:0] model_window(input logic m, input logic [15:0] sc);
    logic [15:0] acc;
    acc = m ? 16'h0000 : 16'hFC00;
    foreach (win[i]) acc = m ? m_add(acc, win[i]) : m_max(acc, win[i]);
    return m ? m_mul(acc, sc) : acc;
  endfunction
  function automatic logic [15:0] rnd_fp();
    int r;
    r = $urandom_range(99, 0);
    if (r < 3) return {1'($urandom), 5'h1F, 10'($urandom_range(1023, 1))};
    if (r < 6) return {1'($urandom), 15'h7C00};
    if (r < 10) return {1'($urandom), 5'd0, 10'($urandom)};
    return {1'($urandom), 5'($urandom_range(20, 10)), 10'($urandom)};
  endfunction
  task automatic run_window(input logic [3:0] k, input logic m, input logic [15:0] sc,
                            input int g_lo, input int g_hi, input bit noise,
                            output logic [15:0] o_om, output logic o_err, output int o_lat,
                            output logic o_saw, output logic o_pv, output logic o_rdy);
    int i, budget;
    o_saw = 0;
    ksize = k; mode = m; avg_scale = sc; pool_ready = 1;
    @(posedge clk); #1;
    pool_ready = 0;
    i = 0;
    while (i < win.size()) begin
      in_valid = 0;
      repeat ($urandom_range(g_hi, g_lo)) begin
        if (noise) begin
          pool_ready = 1;
          ksize = 4'($urandom_range(13, 1));
          mode = ~m;
          in_data = 16'($urandom);
        end
        o_saw |= in_ready;
        @(posedge clk); #1;
      end
      pool_ready = 0;
      in_valid = 1;
      in_data = win[i];
      budget = 0;
      while (!in_ready && budget < 20) begin @(posedge clk); #1; budget++; end
      o_saw |= in_ready;
      @(posedge clk); #1;
      i++;
    end
    in_valid = noise;
    in_data = 16'($urandom);
    o_saw |= in_ready;
    o_lat = 1;
    while (!pool_valid && o_lat < 8) begin
      o_saw |= in_ready;
      @(posedge clk); #1;
      o_lat++;
    end
    o_om = om;
    o_err = err;
    pool_ready = noise && pool_valid;
    @(posedge clk); #1;
    pool_ready = 0;
    in_valid = 0;
    o_pv = pool_valid;
    o_rdy = in_ready;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (om !== 16'h0000) begin errors++; $display("FAIL reset om: got %h want 0000", om); end
    checks++; if (pool_valid !== 1'b0) begin errors++; $display("FAIL reset pool_valid: got %b want 0", pool_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_max3x3();
    win = '{16'h3800, 16'hC000, 16'h4000, 16'h3C00, 16'h3800, 16'h3800, 16'h3C00, 16'hC000, 16'h3800};
    run_window(4'd3, 1'b0, 16'h0, 0, 0, 0, r_om, r_err, lat, saw_rdy, post_valid, post_rdy);
    checks++; if (r_om !== 16'h4000) begin errors++; $display("FAIL max3x3 om: got %h want 4000", r_om); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL max3x3 err: got %b want 0", r_err); end
    checks++; if (lat != 1) begin errors++; $display("FAIL max3x3 latency: got %0d want 1", lat); end
    checks++; if (post_valid !== 1'b0) begin errors++; $display("FAIL max3x3 pulse width: got %b want 0", post_valid); end
  endtask
  task automatic test_avg2x2();
    win = '{16'h3C00, 16'h4000, 16'h4200, 16'h4000};
    run_window(4'd2, 1'b1, 16'h3400, 0, 0, 0, r_om, r_err, lat, saw_rdy, post_valid, post_rdy);
    checks++; if (r_om !== 16'h4000) begin errors++; $display("FAIL avg2x2 om: got %h want 4000", r_om); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL avg2x2 err: got %b want 0", r_err); end
    checks++; if (lat != 2) begin errors++; $display("FAIL avg2x2 latency: got %0d want 2", lat); end
    checks++; if (om !== 16'h4000) begin errors++; $display("FAIL avg2x2 om hold: got %h want 4000", om); end
  endtask
  task automatic test_stalls();
    win = '{16'h3C00, 16'h4000, 16'h4200, 16'h4000};
    run_window(4'd2, 1'b1, 16'h3400, 3, 3, 1, r_om, r_err, lat, saw_rdy, post_valid, post_rdy);
    checks++; if (r_om !== 16'h4000) begin errors++; $display("FAIL stalls om: got %h want 4000", r_om); end
    checks++; if (lat != 2) begin errors++; $display("FAIL stalls latency: got %0d want 2", lat); end
    checks++; if (post_rdy !== 1'b0) begin errors++; $display("FAIL stalls restart in done: in_ready got %b want 0", post_rdy); end
    checks++; if (post_valid !== 1'b0) begin errors++; $display("FAIL stalls pulse width: got %b want 0", post_valid); end
  endtask
  task automatic test_full_size();
    logic [15:0] e;
    win.delete();
    repeat (169) win.push_back(16'h3C00);
    e = model_window(1'b1, 16'h1E0F);
    run_window(4'd13, 1'b1, 16'h1E0F, 0, 0, 0, r_om, r_err, lat, saw_rdy, post_valid, post_rdy);
    checks++; if (r_om !== e) begin errors++; $display("FAIL full om: got %h want %h", r_om, e); end
    checks++; if ((r_om > 16'h3C00 ? r_om - 16'h3C00 : 16'h3C00 - r_om) > 16'd1) begin
      errors++; $display("FAIL full ulp: got %h want within 1 of 3c00", r_om); end
    checks++; if (lat != 2) begin errors++; $display("FAIL full latency: got %0d want 2", lat); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL full err: got %b want 0", r_err); end
  endtask
  task automatic test_illegal();
    logic [3:0] ks[2];
    ks[0] = 4'd0;
    ks[1] = 4'd14;
    win.delete();
    foreach (ks[i]) begin
      run_window(ks[i], 1'b1, 16'h3400, 0, 0, 0, r_om, r_err, lat, saw_rdy, post_valid, post_rdy);
      checks++; if (r_om !== 16'h0000) begin errors++; $display("FAIL illegal k=%0d om: got %h want 0000", ks[i], r_om); end
      checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL illegal k=%0d err: got %b want 1", ks[i], r_err); end
      checks++; if (lat != 1) begin errors++; $display("FAIL illegal k=%0d latency: got %0d want 1", ks[i], lat); end
      checks++; if (saw_rdy !== 1'b0) begin errors++; $display("FAIL illegal k=%0d in_ready: got %b want 0", ks[i], saw_rdy); end
    end
  endtask
  task automatic test_nan_reset();
    logic pv_seen, rdy_seen;
    win = '{16'h3C00, 16'h7E01, 16'h4000, 16'hC000};
    run_window(4'd2, 1'b0, 16'h0, 0, 0, 0, r_om, r_err, lat, saw_rdy, post_valid, post_rdy);
    checks++; if (r_om !== 16'h7E00) begin errors++; $display("FAIL nan max om: got %h want 7e00", r_om); end
    ksize = 4'd3; mode = 1'b1; avg_scale = 16'h2F1C; pool_ready = 1;
    @(posedge clk); #1;
    pool_ready = 0;
    in_valid = 1;
    repeat (5) begin in_data = 16'h3C00; @(posedge clk); #1; end
    in_valid = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    pv_seen = 0;
    rdy_seen = 0;
    repeat (12) begin pv_seen |= pool_valid; rdy_seen |= in_ready; @(posedge clk); #1; end
    checks++; if (pv_seen !== 1'b0) begin errors++; $display("FAIL reset midwindow pool_valid: got %b want 0", pv_seen); end
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL reset midwindow in_ready: got %b want 0", rdy_seen); end
    checks++; if (om !== 16'h0000) begin errors++; $display("FAIL reset midwindow om: got %h want 0000", om); end
    win = '{16'h3800};
    run_window(4'd1, 1'b0, 16'h0, 0, 0, 0, r_om, r_err, lat, saw_rdy, post_valid, post_rdy);
    checks++; if (r_om !== 16'h3800) begin errors++; $display("FAIL after reset 1x1 om: got %h want 3800", r_om); end
    checks++; if (lat != 1) begin errors++; $display("FAIL after reset 1x1 latency: got %0d want 1", lat); end
  endtask
  task automatic test_back_to_back();
    logic [3:0]  k;
    logic        m, ill;
    logic [15:0] sc, e;
    for (int w = 0; w < 40; w++) begin
      k = $urandom_range(99, 0) < 12 ? ($urandom_range(1, 0) == 1 ? 4'd0 : 4'(13 + $urandom_range(2, 1)))
                                    : 4'($urandom_range(5, 1));
      m = 1'($urandom);
      sc = {1'b0, 5'($urandom_range(16, 4)), 10'($urandom)};
      ill = k == 4'd0 || k > 4'd13;
      win.delete();
      if (!ill) repeat (int'(k) * int'(k)) win.push_back(rnd_fp());
      e = ill ? 16'h0000 : model_window(m, sc);
      run_window(k, m, sc, 0, $urandom_range(2, 0), 1'($urandom), r_om, r_err, lat, saw_rdy, post_valid, post_rdy);
      checks++; if (r_om !== e) begin errors++; $display("FAIL random w%0d k=%0d mode=%0d om: got %h want %h", w, k, m, r_om, e); end
      checks++; if (r_err !== ill) begin errors++; $display("FAIL random w%0d err: got %b want %b", w, r_err, ill); end
      checks++; if (lat != (ill ? 1 : m ? 2 : 1)) begin
        errors++; $display("FAIL random w%0d latency: got %0d want %0d", w, lat, ill ? 1 : m ? 2 : 1); end
      checks++; if (post_valid !== 1'b0) begin errors++; $display("FAIL random w%0d pulse width: got %b want 0", w, post_valid); end
    end
  endtask
  initial begin
    test_reset();
    test_max3x3();
    test_avg2x2();
    test_stalls();
    test_full_size();
    test_illegal();
    test_nan_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool_kxk_stream.md
Name: pool_kxk_stream

Overview:
- Parametrised successor to the fixed 13x13 fp16 pooling block.
- Pools one window of up to KMAX x KMAX fp16 activations, streamed one element per cycle, into a single fp16 result.
- Kernel size and MAX/AVG mode are selected at run time per window; AVG applies a host-supplied fp16 reciprocal scale.
- Sits between the activation buffer read port and the output writeback in the pooling path.

Parameters:
- KMAX, 13, largest supported kernel side; window holds at most KMAX*KMAX elements.
- CNT_W, $clog2(KMAX*KMAX+1), width of the element counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- pool_ready  in  1  start strobe; sampled only in IDLE; latches ksize, mode, avg_scale
- ksize  in  4  kernel side, legal range 1..KMAX
- mode  in  1  0 = MAX, 1 = AVG
- avg_scale  in  16  fp16 multiplier used in AVG, normally 1/(ksize*ksize)
- in_valid  in  1  in_data is valid
- in_data  in  16  fp16 window element
- in_ready  out  1  high only in ACCUM
- om  out  16  fp16 result; held until the next start
- pool_valid  out  1  one-cycle pulse when om is updated
- err  out  1  high with pool_valid when the window was rejected

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, acc=0, cnt=0, om=16'h0000, pool_valid=0, err=0, in_ready=0.
- Reset mid-window: the window is discarded. No pool_valid is issued for it.
- States and transitions:
  - IDLE: when pool_ready=1, latch the config.
    - If ksize=0 or ksize>KMAX, go to DONE with om=0 and err=1.
    - Otherwise go to ACCUM with cnt=0 and acc = MAX ? 16'hFC00 (-inf) : 16'h0000.
  - ACCUM: each cycle with in_valid&in_ready accepts one element.
    - MAX: acc = fmax(acc,in_data).
    - AVG: acc = fadd(acc,in_data).
    - cnt increments. After element ksize*ksize is accepted: MAX goes to DONE with om=acc', AVG goes to SCALE.
  - SCALE (AVG only): om = fmul(acc, avg_scale); go to DONE.
  - DONE: pool_valid=1 for exactly one cycle, err as determined; go to IDLE.
- in_valid gaps are allowed; cnt only advances on accepted cycles.
- in_valid outside ACCUM is ignored; in_ready is 0 there.
- pool_ready outside IDLE is ignored.
- pool_ready sampled in the same cycle pool_valid is high is ignored; the earliest restart is the next cycle, in IDLE.
- Latency from the last accepted element to pool_valid:
  - MAX: 1 cycle.
  - AVG: 2 cycles.
- Minimum window period: 1 cycle (start) + N cycles (elements) + 1 or 2 cycles.
- fp16 rules:
  - IEEE binary16.
  - Subnormal inputs and results flush to signed zero.
  - Round-to-nearest-even on add and mul.
  - Overflow goes to +/-inf.
  - Any NaN operand produces canonical NaN 16'h7E00; this also applies to MAX.
  - fmax(+0,-0) = +0.

Decomposition:
- Shared package pool_pkg:
  - fp16 constants: FP16_ZERO, FP16_NEG_INF=16'hFC00, FP16_QNAN=16'h7E00.
  - MODE_MAX/MODE_AVG encodings.
  - State encodings IDLE/ACCUM/SCALE/DONE.
- One sub-module fp16_alu: combinational, op select {MAX, ADD, MUL}.
  - Instanced once and shared, since ACCUM and SCALE never overlap.
- The FSM, counter and registers stay in pool_kxk_stream.

Test Plan:
- MAX 3x3: ksize=3, mode=0, elements {3800,C000,4000,3C00,3800,3800,3C00,C000,3800}, continuous valid -> pool_valid 1 cycle after the 9th element; om=16'h4000, err=0.
- AVG 2x2: ksize=2, mode=1, avg_scale=16'h3400, elements {3C00,4000,4200,4000} -> om=16'h4000 (8.0*0.25) 2 cycles after the last element.
- Stalls and illegal inputs: the AVG 2x2 window with in_valid low for 3 cycles between elements, plus pool_ready pulsed during ACCUM -> same om=16'h4000; the extra pool_ready has no effect; cnt advances only on accepted cycles.
- Full size: ksize=13, AVG, 169 elements of 16'h3C00, avg_scale=16'h1E0F -> om is fp16 of 169*(1/169) per fp16_alu rounding, within 1 ulp of 16'h3C00.
- Illegal size: ksize=0, then ksize=14 -> each gives pool_valid the cycle after the start cycle, om=0, err=1, and in_ready never asserts.
- NaN and reset: a NaN element (7E01) in a MAX window gives om=16'h7E00. A separate AVG window with rst_n low after 5 elements gives no pool_valid, and a following 1x1 MAX window {3800} outputs om=16'h3800.
